// File: rtl/median_filter_pkg.sv
// median_filter_pkg: FSM encoding, tap/rank sizing helpers and parameter sanity check
package median_filter_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;
    function automatic int ntaps(input int k);
        return k * k;
    endfunction
    function automatic int rank_w(input int k);
        return $clog2(k * k);
    endfunction
    function automatic bit params_ok(input int k, input int stride, input int img_w, input int img_h,
                                     input int pix_w, input int addr_w, input int rd_lat);
        return k % 2 == 1 && k >= 3 && k <= 7 && stride >= 1 && stride <= k &&
               img_w >= k && img_h >= k && pix_w >= 1 && pix_w <= 16 &&
               img_w - 1 < (1 << addr_w) && img_h - 1 < (1 << addr_w) &&
               rd_lat >= 1 && rd_lat <= 4;
    endfunction
endpackage

// File: rtl/median_window_engine_rank_sorter.sv
// rank_sorter: insertion-sorts one pixel per cycle and exposes any rank combinationally
module rank_sorter #(
    parameter int NTAPS = 9,
    parameter int PIX_W = 1,
    parameter int RANK_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              insert,
    input  logic [PIX_W-1:0]  din,
    input  logic [RANK_W-1:0] rank,
    output logic [PIX_W-1:0]  dout
);
    localparam int CW = $clog2(NTAPS + 1);
    logic [PIX_W-1:0] arr [NTAPS];
    logic [PIX_W-1:0] nxt [NTAPS];
    logic [NTAPS-1:0] gt;
    logic [NTAPS-1:0] hit;
    logic [CW-1:0] n;
    // new value lands after every stored value <= it, so equal values keep arrival order
    always_comb begin
        gt = '0;
        hit = '0;
        for (int i = 0; i < NTAPS; i++) begin
            gt[i] = CW'(i) < n && arr[i] > din;
            hit[i] = gt[i] || CW'(i) == n;
        end
        nxt[0] = hit[0] ? din : arr[0];
        for (int i = 1; i < NTAPS; i++)
            nxt[i] = hit[i] ? (gt[i-1] ? arr[i-1] : din) : arr[i];
    end
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            n <= '0;
            for (int i = 0; i < NTAPS; i++) arr[i] <= '0;
        end else if (insert && n != CW'(NTAPS)) begin
            n <= n + 1'b1;
            for (int i = 0; i < NTAPS; i++) arr[i] <= nxt[i];
        end
    end
    assign dout = arr[rank];
endmodule

// File: rtl/median_window_engine.sv
// median_window_engine: scans a KxK window over a frame and writes the selected order statistic
module median_window_engine
    import median_filter_pkg::*;
#(
    parameter int K = 3,
    parameter int STRIDE = 1,
    parameter int IMG_W = 240,
    parameter int IMG_H = 180,
    parameter int PIX_W = 1,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [rank_w(K)-1:0] rank_sel,
    output logic                 filter_ready,
    output logic                 filter_done,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_x,
    output logic [ADDR_W-1:0]    rd_y,
    input  logic [PIX_W-1:0]     rd_data,
    output logic                 wr_en,
    input  logic                 wr_ready,
    output logic [ADDR_W-1:0]    wr_x,
    output logic [ADDR_W-1:0]    wr_y,
    output logic [PIX_W-1:0]     wr_data
);
    localparam int NTAPS = ntaps(K);
    localparam int RANK_W = rank_w(K);
    localparam int TW = $clog2(K);
    localparam int DW = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'((IMG_W - K) / STRIDE * STRIDE);
    localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'((IMG_H - K) / STRIDE * STRIDE);
    localparam logic [ADDR_W-1:0] HALF = ADDR_W'(K / 2);
    localparam logic [TW-1:0] T_LAST = TW'(K - 1);
    localparam logic [RANK_W-1:0] R_MAX = RANK_W'(NTAPS - 1);

    if (!params_ok(K, STRIDE, IMG_W, IMG_H, PIX_W, ADDR_W, RD_LAT)) begin : g_bad_params
        $error("median_window_engine: unsupported parameter set");
    end

    state_t state, next;
    logic [ADDR_W-1:0] win_x, win_y;
    logic [TW-1:0] tx, ty;
    logic [DW-1:0] dcnt;
    logic [RD_LAT-1:0] vpipe;
    logic [RANK_W-1:0] rank;
    logic [PIX_W-1:0] sel;
    logic tap_last, win_last, clear;

    always_comb begin
        tap_last = tx == T_LAST && ty == T_LAST;
        win_last = win_x == X_LAST && win_y == Y_LAST;
        next = state;
        case (state)
            IDLE:    next = start ? ISSUE : IDLE;
            ISSUE:   next = tap_last ? DRAIN : ISSUE;
            DRAIN:   next = dcnt == DW'(RD_LAT - 1) ? WRITE : DRAIN;
            WRITE:   next = !wr_ready ? WRITE : win_last ? DONE : ISSUE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // addresses are gated so idle outputs read as zero
    always_comb begin
        filter_ready = state == IDLE;
        filter_done = state == DONE;
        rd_en = state == ISSUE;
        wr_en = state == WRITE;
        clear = rd_en && tx == '0 && ty == '0;
        rd_x = rd_en ? win_x + ADDR_W'(tx) : '0;
        rd_y = rd_en ? win_y + ADDR_W'(ty) : '0;
        wr_x = wr_en ? win_x + HALF : '0;
        wr_y = wr_en ? win_y + HALF : '0;
        wr_data = wr_en ? sel : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_x <= '0;
            win_y <= '0;
            tx <= '0;
            ty <= '0;
            dcnt <= '0;
            vpipe <= '0;
            rank <= '0;
        end else begin
            vpipe[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];
            dcnt <= state == DRAIN ? dcnt + 1'b1 : '0;
            if (state == IDLE && start) begin
                rank <= rank_sel > R_MAX ? R_MAX : rank_sel;
                win_x <= '0;
                win_y <= '0;
            end
            if (rd_en) begin
                tx <= tx == T_LAST ? '0 : tx + 1'b1;
                if (tx == T_LAST) ty <= ty == T_LAST ? '0 : ty + 1'b1;
            end
            if (wr_en && wr_ready) begin
                win_x <= win_x == X_LAST ? '0 : win_x + ADDR_W'(STRIDE);
                if (win_x == X_LAST) win_y <= win_y + ADDR_W'(STRIDE);
            end
        end
    end

    rank_sorter #(
        .NTAPS(NTAPS),
        .PIX_W(PIX_W),
        .RANK_W(RANK_W)
    ) u_sorter (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .insert(vpipe[RD_LAT-1]),
        .din(rd_data),
        .rank(rank),
        .dout(sel)
    );
endmodule
